// File: rtl/irrigation_valve_sequencer.sv
// irrigation_valve_sequencer: tick-aligned valve timing with cooldown and counter-stall fault
module irrigation_valve_sequencer #(
  parameter int DURATION_TICKS = 6,
  parameter int COOLDOWN_TICKS = 3,
  parameter int TICK_WIDTH     = 8,
  parameter int STALL_LIMIT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            count_in,
  input  logic                  dry,
  input  logic                  manual_stop,
  output logic                  valve_open,
  output logic                  busy,
  output logic                  cycle_done,
  output logic [TICK_WIDTH-1:0] ticks_left,
  output logic                  fault
);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  typedef enum logic [2:0] {IDLE, WAIT_SYNC, WATERING, COOLDOWN, FAULT} state_t;
  state_t state, state_n;
  logic [3:0] prev_count;
  logic [SW-1:0] stall_cnt, stall_n;
  logic [TICK_WIDTH-1:0] tl_n;
  logic valve_n, done_n, tick, last;
  assign tick = prev_count != 4'd0 && count_in == 4'd0;
  assign last = ticks_left == TICK_WIDTH'(1);
  assign stall_n = count_in != prev_count ? '0 :
                   stall_cnt == SW'(STALL_LIMIT) ? stall_cnt : stall_cnt + 1'b1;
  always_comb begin
    state_n = state;
    tl_n    = ticks_left;
    valve_n = valve_open;
    done_n  = 1'b0;
    if (stall_n == SW'(STALL_LIMIT)) begin
      state_n = FAULT;
      tl_n    = '0;
      valve_n = 1'b0;
    end else begin
      case (state)
        IDLE: state_n = dry ? WAIT_SYNC : IDLE;
        WAIT_SYNC:
          if (!dry) state_n = IDLE;
          else if (tick) begin
            state_n = WATERING;
            tl_n    = TICK_WIDTH'(DURATION_TICKS);
            valve_n = 1'b1;
          end
        // manual_stop skips the completion pulse but still enforces cooldown
        WATERING:
          if (manual_stop || (tick && last)) begin
            state_n = COOLDOWN;
            tl_n    = TICK_WIDTH'(COOLDOWN_TICKS);
            valve_n = 1'b0;
            done_n  = !manual_stop;
          end else if (tick) tl_n = ticks_left - 1'b1;
        COOLDOWN:
          if (tick) begin
            state_n = last ? IDLE : COOLDOWN;
            tl_n    = ticks_left - 1'b1;
          end
        default: begin
          state_n = FAULT;
          tl_n    = '0;
          valve_n = 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      prev_count <= '0;
      stall_cnt  <= '0;
      valve_open <= 1'b0;
      busy       <= 1'b0;
      cycle_done <= 1'b0;
      ticks_left <= '0;
      fault      <= 1'b0;
    end else begin
      state      <= state_n;
      prev_count <= count_in;
      stall_cnt  <= stall_n;
      valve_open <= valve_n;
      busy       <= state_n inside {WAIT_SYNC, WATERING, COOLDOWN};
      cycle_done <= done_n;
      ticks_left <= tl_n;
      fault      <= state_n == FAULT;
    end
  end
endmodule

// File: tb/tb_irrigation_valve_sequencer.sv
// tb_irrigation_valve_sequencer: directed scenarios checked against a phase/timer reference model
module tb_irrigation_valve_sequencer;
  localparam int DUR = 6, COOL = 3, LIMIT = 16;
  localparam int P_IDLE = 0, P_ARMED = 1, P_OPEN = 2, P_COOL = 3, P_FLT = 4;
  logic clk = 1'b0, reset = 1'b1, dry = 1'b0, manual_stop = 1'b0;
  logic [3:0] count_in = 4'd0;
  logic valve_open, busy, cycle_done, fault;
  logic [7:0] ticks_left;
  int tests = 0, fails = 0;
  int m_prev, m_stall, m_phase, m_left, m_done;
  int vcyc, done_cnt, done_tl, rise_cnt;
  logic vprev, freeze = 1'b0;

  irrigation_valve_sequencer #(.DURATION_TICKS(DUR), .COOLDOWN_TICKS(COOL), .TICK_WIDTH(8),
    .STALL_LIMIT(LIMIT)) dut (.clk(clk), .reset(reset), .count_in(count_in), .dry(dry),
    .manual_stop(manual_stop), .valve_open(valve_open), .busy(busy), .cycle_done(cycle_done),
    .ticks_left(ticks_left), .fault(fault));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a phase plus a remaining-tick timer, advanced once per clock
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_prev = 0; m_stall = 0; m_phase = P_IDLE; m_left = 0; m_done = 0;
    end else begin
      bit tk;
      tk = m_prev != 0 && count_in == 0;
      m_stall = (count_in == m_prev) ? (m_stall < LIMIT ? m_stall + 1 : LIMIT) : 0;
      m_done = 0;
      if (m_phase == P_FLT || m_stall >= LIMIT) begin
        m_phase = P_FLT; m_left = 0;
      end else if (m_phase == P_OPEN && manual_stop) begin
        m_phase = P_COOL; m_left = COOL;
      end else if (tk && m_phase == P_OPEN) begin
        m_left--;
        if (m_left == 0) begin m_phase = P_COOL; m_left = COOL; m_done = 1; end
      end else if (tk && m_phase == P_COOL) begin
        m_left--;
        if (m_left == 0) m_phase = P_IDLE;
      end else if (m_phase == P_ARMED && !dry) m_phase = P_IDLE;
      else if (m_phase == P_ARMED && tk) begin m_phase = P_OPEN; m_left = DUR; end
      else if (m_phase == P_IDLE && dry) m_phase = P_ARMED;
      m_prev = count_in;
    end
  end

  always @(negedge clk) if (!reset) begin
    chk("valve_open", valve_open, m_phase == P_OPEN);
    chk("busy", busy, m_phase inside {P_ARMED, P_OPEN, P_COOL});
    chk("cycle_done", cycle_done, m_done);
    chk("ticks_left", ticks_left, m_left);
    chk("fault", fault, m_phase == P_FLT);
    if (valve_open) vcyc++;
    if (valve_open && !vprev) rise_cnt = count_in;
    if (cycle_done) begin done_cnt++; done_tl = ticks_left; end
    vprev = valve_open;
  end

  task automatic step();
    @(negedge clk); #1;
    if (!freeze) count_in = (count_in == 4'd9) ? 4'd0 : count_in + 4'd1;
  endtask

  task automatic wait_count(input int v);
    for (int i = 0; i < 12 && count_in != v; i++) step();
  endtask

  task automatic wait_valve(input string name);
    for (int i = 0; i < 40 && !valve_open; i++) step();
    chk(name, valve_open, 1);
  endtask

  initial begin
    vprev = 1'b0; vcyc = 0; done_cnt = 0; done_tl = -1; rise_cnt = -1;
    repeat (3) step();
    chk("rst_valve", valve_open, 0);
    chk("rst_ticks", ticks_left, 0);
    reset = 1'b0;
    repeat (25) step();
    chk("idle_busy", busy, 0);
    chk("idle_fault", fault, 0);
    // Full watering cycle
    wait_count(4);
    dry = 1'b1; vcyc = 0; done_cnt = 0;
    wait_valve("open_wait");
    dry = 1'b0;
    repeat (100) step();
    chk("rise_at_wrap", rise_cnt, 0);
    chk("open_cycles", vcyc, 60);
    chk("done_pulses", done_cnt, 1);
    chk("done_ticks", done_tl, 3);
    chk("back_idle", busy, 0);
    // Manual stop part-way through watering
    dry = 1'b1;
    wait_valve("stop_open_wait");
    dry = 1'b0;
    for (int i = 0; i < 60 && ticks_left != 4; i++) step();
    chk("reach_tl4", ticks_left, 4);
    manual_stop = 1'b1; done_cnt = 0;
    step();
    manual_stop = 1'b0;
    chk("stop_valve", valve_open, 0);
    chk("stop_ticks", ticks_left, 3);
    repeat (35) step();
    chk("stop_no_done", done_cnt, 0);
    chk("stop_idle", busy, 0);
    // Request withdrawn before the wrap
    wait_count(2);
    dry = 1'b1; vcyc = 0;
    step();
    chk("armed_busy", busy, 1);
    step(); step();
    dry = 1'b0;
    repeat (30) step();
    chk("drop_no_open", vcyc, 0);
    chk("drop_idle", busy, 0);
    // Counter stall while watering
    dry = 1'b1;
    wait_valve("stall_open_wait");
    dry = 1'b0;
    wait_count(5);
    freeze = 1'b1;
    repeat (20) step();
    chk("stall_fault", fault, 1);
    chk("stall_valve", valve_open, 0);
    freeze = 1'b0;
    repeat (20) step();
    chk("fault_sticky", fault, 1);
    chk("fault_busy", busy, 0);
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    chk("fault_cleared", fault, 0);
    // Asynchronous reset while the valve is open
    dry = 1'b1;
    wait_valve("async_open_wait");
    repeat (3) step();
    #2 reset = 1'b1;
    #1 chk("async_valve", valve_open, 0);
    chk("async_busy", busy, 0);
    step();
    dry = 1'b0; reset = 1'b0;
    repeat (5) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
